// File: rtl/pwm_audio_rx.sv
// Pulse-width audio link receiver: measures burst/silence durations on the
// synchronized line and rebuilds each WIDTH-bit sample, MSB first.
`timescale 1ns/1ps
module pwm_audio_rx #(
  parameter int SBD    = 800,
  parameter int SSD    = 800,
  parameter int BBD    = 400,
  parameter int BSD0   = 200,
  parameter int BSD1   = 400,
  parameter int WIDTH  = 8,
  parameter int MARGIN = 50
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             signal_in,
  output logic [WIDTH-1:0] audio_out,
  output logic             valid_out,
  output logic             error_out,
  output logic             busy_out
);

  localparam int MAX_A   = (SBD > SSD) ? SBD : SSD;
  localparam int MAX_B   = (BBD > BSD1) ? BBD : BSD1;
  localparam int MAX_LEN = ((MAX_A > MAX_B) ? MAX_A : MAX_B) + MARGIN;
  localparam int IW      = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SYNC_H, SYNC_L, BIT_H, BIT_L} state_t;

  state_t           state_reg, state_next;
  logic             sync1_reg, sync2_reg, level_reg;
  logic [15:0]      cnt_reg;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] audio_next;
  logic             valid_next, error_next;
  logic             rise, fall, timeout;
  logic [16:0]      dur;

  function automatic logic match(input logic [16:0] d, input int n);
    int diff;
    diff = 32'(d) - n;
    return (diff <= MARGIN) && (diff >= -MARGIN);
  endfunction

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
    end else begin
      sync1_reg <= signal_in;
      sync2_reg <= sync1_reg;
      level_reg <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~level_reg;
  assign fall = ~sync2_reg & level_reg;

  // Counter restarts at zero on each edge, so the held duration is cnt+1.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_reg <= '0;
    end else if (rise || fall) begin
      cnt_reg <= '0;
    end else if (cnt_reg != 16'hFFFF) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign dur     = {1'b0, cnt_reg} + 17'd1;
  assign timeout = (cnt_reg >= 16'(MAX_LEN)) && !rise && !fall;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    audio_next = audio_out;
    valid_next = 1'b0;
    error_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise) state_next = SYNC_H;
      end
      SYNC_H: begin
        if (fall) begin
          if (match(dur, SBD)) begin
            state_next = SYNC_L;
          end else begin
            error_next = 1'b1;
            state_next = IDLE;
          end
        end
      end
      SYNC_L: begin
        if (rise) begin
          if (match(dur, SSD)) begin
            state_next = BIT_H;
            idx_next   = IW'(WIDTH);
            shift_next = '0;
          end else begin
            error_next = 1'b1;
            state_next = SYNC_H;
          end
        end
      end
      BIT_H: begin
        if (fall) begin
          if (!match(dur, BBD)) begin
            error_next = 1'b1;
            state_next = IDLE;
          end else if (idx_reg != '0) begin
            state_next = BIT_L;
          end else begin
            audio_next = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end
        end
      end
      BIT_L: begin
        // A failed window on a rising edge re-arms on that same edge.
        if (rise) begin
          if (match(dur, BSD0) || match(dur, BSD1)) begin
            shift_next = (shift_reg << 1) | WIDTH'(match(dur, BSD1));
            idx_next   = idx_reg - IW'(1);
            state_next = BIT_H;
          end else begin
            error_next = 1'b1;
            state_next = SYNC_H;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_reg != IDLE && timeout) begin
      error_next = 1'b1;
      valid_next = 1'b0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      shift_reg <= '0;
      audio_out <= '0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
      busy_out  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      audio_out <= audio_next;
      valid_out <= valid_next;
      error_out <= error_next;
      busy_out  <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_pwm_audio_rx.sv
// Bench for pwm_audio_rx: drives segment-list waveforms with random jitter and
// checks every cycle against a duration-list frame parser.
`timescale 1ns/1ps
module tb_pwm_audio_rx;
  localparam int SBD = 800, SSD = 800, BBD = 400, BSD0 = 200, BSD1 = 400;
  localparam int WIDTH = 8, MARGIN = 50;
  localparam int MAX_LEN = 850;

  logic clk = 1'b0, rst_n = 1'b0, sig = 1'b0;
  logic [WIDTH-1:0] audio;
  logic valid, error, busy;

  pwm_audio_rx #(.SBD(SBD), .SSD(SSD), .BBD(BBD), .BSD0(BSD0), .BSD1(BSD1),
                 .WIDTH(WIDTH), .MARGIN(MARGIN)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .signal_in(sig),
    .audio_out(audio), .valid_out(valid), .error_out(error), .busy_out(busy));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int vcount = 0, ecount = 0;
  logic [7:0] vq[$];
  int seg[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: frame = list of level durations ----
  logic [3:0] xh;
  logic y, y_prev;
  int run, pos, acc;
  bit in_frame, m_valid, m_error;
  logic [7:0] m_audio;

  function automatic bit win(input int d, input int n);
    return (d - n <= MARGIN) && (n - d <= MARGIN);
  endfunction

  task automatic reject(input logic lvl);
    m_error = 1'b1;
    in_frame = lvl;   // a rising edge starts a fresh sync burst
    pos = 0;
    acc = 0;
  endtask

  task automatic step_edge(input int d, input logic lvl);
    if (!in_frame) begin
      if (lvl) begin in_frame = 1'b1; pos = 0; acc = 0; end
    end else if (pos == 0) begin
      if (win(d, SBD)) pos = 1; else reject(lvl);
    end else if (pos == 1) begin
      if (win(d, SSD)) pos = 2; else reject(lvl);
    end else if (pos % 2 == 0) begin
      if (!win(d, BBD)) reject(lvl);
      else if (pos == 2 + 2 * WIDTH) begin
        m_valid = 1'b1; m_audio = acc[7:0]; in_frame = 1'b0;
      end else pos++;
    end else begin
      if (win(d, BSD0)) begin acc = acc * 2; pos++; end
      else if (win(d, BSD1)) begin acc = acc * 2 + 1; pos++; end
      else reject(lvl);
    end
  endtask

  always @(negedge clk) begin
    m_valid = 1'b0;
    m_error = 1'b0;
    if (!rst_n) begin
      xh = {3'b000, sig};
      y_prev = 1'b0; run = 1; in_frame = 1'b0; pos = 0; acc = 0; m_audio = 8'h00;
    end else begin
      xh = {xh[2:0], sig};
      y = xh[3];   // line as seen after synchronizer plus edge register
      if (y != y_prev) begin
        step_edge(run, y);
        run = 1;
      end else begin
        if (in_frame && run == MAX_LEN + 1) begin m_error = 1'b1; in_frame = 1'b0; end
        if (run < 65536) run++;
      end
      y_prev = y;
    end
    chk("valid", 32'(valid), 32'(m_valid));
    chk("error", 32'(error), 32'(m_error));
    chk("busy", 32'(busy), 32'(in_frame));
    chk("audio", 32'(audio), 32'(m_audio));
    if (valid) begin vq.push_back(audio); vcount++; end
    if (error) ecount++;
  end

  // ---------------- stimulus helpers ----------------
  function automatic int jit(input bit en);
    return en ? int'($urandom_range(0, 2 * MARGIN)) - MARGIN : 0;
  endfunction

  task automatic build(input logic [7:0] v, input bit en);
    seg.delete();
    seg.push_back(SBD + jit(en));
    seg.push_back(SSD + jit(en));
    for (int i = 7; i >= 0; i--) begin
      seg.push_back(BBD + jit(en));
      seg.push_back((v[i] ? BSD1 : BSD0) + jit(en));
    end
    seg.push_back(BBD + jit(en));
  endtask

  task automatic trim(input int n);
    while (seg.size() > n) void'(seg.pop_back());
  endtask

  task automatic hold(input logic l, input int n);
    sig = l;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic play();
    for (int i = 0; i < seg.size(); i++) hold((i % 2) == 0, seg[i]);
  endtask

  function automatic logic [31:0] vq_at(input int i);
    if (i < vq.size()) return 32'(vq[i]);
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_audio", 32'(audio), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #2;
    hold(0, 20);

    // ideal 0xA5, latency and busy release
    build(8'hA5, 1'b0);
    play();
    hold(0, 2);
    chk("t1_valid_early", 32'(valid), 32'h0);
    chk("t1_busy_early", 32'(busy), 32'h1);
    hold(0, 1);
    chk("t1_valid", 32'(valid), 32'h1);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_audio", 32'(audio), 32'hA5);
    hold(0, 50);
    chk("t1_vcount", 32'(vcount), 32'd1);
    chk("t1_ecount", 32'(ecount), 32'd0);

    // back-to-back 0x00 then 0xFF
    build(8'h00, 1'b1); play(); hold(0, 1);
    build(8'hFF, 1'b1); play(); hold(0, 30 + int'($urandom_range(0, 200)));
    chk("t2_vcount", 32'(vcount), 32'd3);
    chk("t2_first", vq_at(1), 32'h00);
    chk("t2_second", vq_at(2), 32'hFF);

    // silence window edge: 450 accepted, 451 rejected
    build(8'h80, 1'b1); seg[3] = BSD1 + MARGIN; play(); hold(0, 100);
    chk("t3_vcount", 32'(vcount), 32'd4);
    chk("t3_audio", 32'(audio), 32'h80);
    build(8'h80, 1'b1); seg[3] = BSD1 + MARGIN + 1; trim(5); play(); hold(0, 100);
    chk("t3_ecount", 32'(ecount), 32'd2);
    chk("t3_vcount_hold", 32'(vcount), 32'd4);
    chk("t3_audio_hold", 32'(audio), 32'h80);

    // short sync burst, then 0x3C
    hold(1, 500); hold(0, 200);
    chk("t4_ecount", 32'(ecount), 32'd3);
    build(8'h3C, 1'b1); play(); hold(0, 60);
    chk("t4_audio", 32'(audio), 32'h3C);
    chk("t4_vcount", 32'(vcount), 32'd5);

    // short sync low, rising edge resyncs into 0x5A
    hold(1, SBD); hold(0, 300);
    build(8'h5A, 1'b1); play(); hold(0, 60);
    chk("t5_ecount", 32'(ecount), 32'd4);
    chk("t5_audio", 32'(audio), 32'h5A);
    chk("t5_vcount", 32'(vcount), 32'd6);

    // timeout after three bits
    build(8'hE7, 1'b1); trim(7); play();
    hold(0, 853);
    chk("t6_err_early", 32'(error), 32'h0);
    chk("t6_busy_early", 32'(busy), 32'h1);
    hold(0, 1);
    chk("t6_timeout", 32'(error), 32'h1);
    chk("t6_busy", 32'(busy), 32'h0);
    hold(0, 146);
    chk("t6_ecount", 32'(ecount), 32'd5);

    // reset mid-frame with the line high, then 0x11
    build(8'h11, 1'b1); trim(5); play(); hold(1, 150);
    #1 rst_n = 1'b0;
    #1;
    chk("r_audio", 32'(audio), 32'h0);
    chk("r_valid", 32'(valid), 32'h0);
    chk("r_error", 32'(error), 32'h0);
    chk("r_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #2;
    hold(1, 200); hold(0, 100);
    chk("r_remainder_err", 32'(ecount), 32'd6);
    build(8'h11, 1'b1); play(); hold(0, 60);
    chk("r_audio_11", 32'(audio), 32'h11);
    chk("r_vcount", 32'(vcount), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pwm_audio_rx.md
Name: pwm_audio_rx

Overview:
- Receive-side decoder for the pulse-width audio link.
- Consumes the single-wire burst/silence waveform produced by the audio transmitter after the optical/IR front end and rebuilds each WIDTH-bit audio sample.
- Presents each decoded sample with a one-cycle valid strobe, flags malformed frames and re-arms automatically for the next frame.

Parameters:
- SBD, 800: sync burst (high) duration, cycles.
- SSD, 800: sync silence (low) duration, cycles.
- BBD, 400: bit burst (high) duration and trailing burst duration, cycles.
- BSD0, 200: silence duration encoding 0, cycles.
- BSD1, 400: silence duration encoding 1, cycles.
- WIDTH, 8: sample bit depth.
- MARGIN, 50: accepted ± deviation on every measured duration. Must be < (BSD1-BSD0)/2.

Ports:
- clk_in  input  1  system clock (98.3 MHz).
- rst_n_in  input  1  asynchronous active-low reset.
- signal_in  input  1  raw link waveform, asynchronous to clk_in.
- audio_out  output  WIDTH  last decoded sample.
- valid_out  output  1  one-cycle strobe, new audio_out.
- error_out  output  1  one-cycle strobe, frame rejected.
- busy_out  output  1  frame decode in progress.

Behaviour:
- Reset (rst_n_in low, asynchronous): synchronizer flops, state, counter, shift register and all outputs go to 0; state = IDLE.
- Input path: 2-flop synchronizer, then a registered edge detector.
- Duration D: number of clk_in cycles the synchronized level held between two edges. An ideal N-cycle pulse measures exactly N.
- Level counter: 16-bit, saturating, cleared on every edge.
- match(D,N) := |D-N| <= MARGIN.
- MAX_LEN = max(SBD,SSD,BBD,BSD1)+MARGIN.
- States and transitions:
  - IDLE: rising edge -> SYNC_H.
  - SYNC_H: falling edge with match(D,SBD) -> SYNC_L, else error.
  - SYNC_L: rising edge with match(D,SSD) -> BIT_H, bit index = WIDTH, else error.
  - BIT_H: falling edge with match(D,BBD): index > 0 -> BIT_L; index == 0 (trailing burst) -> DONE action. Mismatch -> error.
  - BIT_L: rising edge with match(D,BSD0) shifts in 0; match(D,BSD1) shifts in 1; index decrements and state -> BIT_H. Neither window matches -> error.
- Bit order: MSB first, shift left into LSB. After WIDTH bits the shift register holds the sample exactly as transmitted.
- DONE action: audio_out <= shift register; valid_out high for 1 cycle; state -> IDLE.
- Latency: valid_out rises 3 cycles after signal_in falls at the end of the trailing burst (2 sync + 1 register).
- audio_out changes only on valid_out and holds its value otherwise, including across errors.
- Error handling: error_out high for 1 cycle. valid_out is never asserted for that frame and the shift register is discarded.
  - Error detected on a falling edge: state -> IDLE.
  - Error detected on a rising edge: state -> SYNC_H, with that edge taken as a new sync start (resync, no lost frame).
- Timeout: in any non-IDLE state, the level counter reaching MAX_LEN+1 without an edge -> error, state -> IDLE.
- valid_out and error_out are never high in the same cycle.
- busy_out = (state != IDLE), registered. It goes high the cycle after the rising edge is seen and low in the same cycle that valid_out or error_out pulses.
- Glitches: a pulse shorter than BSD0-MARGIN in any non-IDLE state fails its window -> error.
- Line already high at reset release: it appears as a rising edge -> SYNC_H. A short remainder then errors, which is acceptable.
- Back-to-back frames: a new rising edge on the cycle after DONE is accepted from IDLE.

Test Plan:
1. Default parameters, ideal waveform for 0xA5 -> exactly one valid_out, audio_out=0xA5, error_out never high, busy_out low 3 cycles after the final fall.
2. Frames 0x00 then 0xFF back to back with zero idle gap -> two valid_out pulses, audio_out 0x00 then 0xFF.
3. 0x80 with the bit-7 silence at 450 cycles (BSD1+MARGIN) -> decoded 0x80. Repeat with 451 -> error_out pulse, no valid_out, audio_out keeps its previous value.
4. Sync burst of 500 cycles -> error_out on its falling edge, state IDLE. A correct frame 0x3C immediately after -> valid_out with 0x3C.
5. Sync low of 300 cycles then a full frame 0x5A starting at that rising edge -> error_out, then resync yields valid_out with 0x5A.
6. Line held low for 1000 cycles after 3 bits -> error_out when the counter passes 850, busy_out drops. rst_n_in pulsed low mid-frame -> all outputs 0 immediately, and the next full frame 0x11 decodes correctly.
